// File: rtl/mul_sequencer.sv
// Sequenced 32x32 multiplier supporting MUL/MULH/MULHSU/MULHU. Operands are reduced to
// magnitudes, multiplied by one unsigned carry-save array, then the sign is re-applied.

module Multiplier32_no_booth (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic [63:0] sum;
    logic [63:0] carry;
    logic [63:0] pp;
    logic [63:0] t;

    // Carry-save reduction of the 32 partial products, one final carry-propagate add.
    always_comb begin
        sum   = '0;
        carry = '0;
        pp    = '0;
        t     = '0;
        for (int i = 0; i < 32; i++) begin
            pp    = b[i] ? (64'(a) << i) : 64'd0;
            t     = sum ^ carry ^ pp;
            carry = ((sum & carry) | (sum & pp) | (carry & pp)) << 1;
            sum   = t;
        end
        p = sum + carry;
    end
endmodule

module mul_sequencer #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy,
    output logic [31:0] done_count
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t             state, state_nx;
    logic [3:0]         cnt_p0, cnt_nx;
    logic [1:0]         op_p0;
    logic               sign_a_p0, sign_b_p0;
    logic [31:0]        mag_a_p0, mag_b_p0;
    logic [63:0]        mul_out;
    logic [63:0]        prod_p1;
    logic signed [63:0] prod_fix;
    logic [31:0]        fix_word;
    logic               accept;
    logic               a_signed, b_signed;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic signed [63:0] apply_sign64(input logic [63:0] p, input logic neg);
        return neg ? signed'(~p + 64'd1) : signed'(p);
    endfunction

    assign in_ready  = (state == IDLE) && !flush && rst_n;
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign a_signed  = (in_op == 2'b01) || (in_op == 2'b10);
    assign b_signed  = (in_op == 2'b01);

    Multiplier32_no_booth u_mul (
        .a (mag_a_p0),
        .b (mag_b_p0),
        .p (mul_out)
    );

    assign prod_fix = apply_sign64(prod_p1, sign_a_p0 ^ sign_b_p0);
    assign fix_word = (op_p0 == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_p0;
        unique case (state)
            IDLE: if (accept) begin
                state_nx = CALC;
                cnt_nx   = CNT_LOAD;
            end
            CALC: if (cnt_p0 == 4'd0) state_nx = FIX;
                  else                cnt_nx   = cnt_p0 - 4'd1;
            FIX:  state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt_p0     <= 4'd0;
            out_result <= 32'd0;
            done_count <= 32'd0;
        end else begin
            state  <= state_nx;
            cnt_p0 <= cnt_nx;
            if (state == FIX && !flush)
                out_result <= fix_word;
            if (state == DONE && out_ready && !flush)
                done_count <= done_count + 32'd1;
        end
    end

    // p0: operand capture; p1: product capture at the end of CALC
    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0     <= in_op;
            sign_a_p0 <= a_signed && in_a[31];
            sign_b_p0 <= b_signed && in_b[31];
            mag_a_p0  <= mag32(in_a, a_signed);
            mag_b_p0  <= mag32(in_b, b_signed);
        end
        if (state == CALC && cnt_p0 == 4'd0 && !flush)
            prod_p1 <= mul_out;
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed operations, handshake stalls, flush,
// asynchronous reset and a LATENCY=1 instance.

module tb_mul_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [1:0]  in_op;
    logic [31:0] in_a, in_b, out_result, done_count;

    logic        v2, rdy2, ov2, ordy2, busy2;
    logic [1:0]  op2;
    logic [31:0] a2, b2, res2, dc2;

    int          checks = 0;
    int          failures = 0;
    int          exp_done = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    mul_sequencer #(.LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .busy(busy), .done_count(done_count)
    );

    mul_sequencer #(.LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_op(op2), .in_a(a2), .in_b(b2), .flush(1'b0),
        .out_valid(ov2), .out_ready(ordy2), .out_result(res2),
        .busy(busy2), .done_count(dc2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // Monitor: every handoff pops the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=0x%08h expected=none", out_result);
            end else begin
                chk("result", out_result, sbq.pop_front());
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input bit push);
        int k;
        @(negedge clk);
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
        chk1("in_ready_idle", in_ready, 1'b1);
        if (push) sbq.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0; in_op = ~op; in_a = ~a ^ 32'h5a5a; in_b = b + 32'd3;
        k = 1;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("latency", 32'(k), 32'd4);
    endtask

    task automatic handoff();
        chk1("in_ready_done", in_ready, 1'b0);
        exp_done++;
        @(posedge clk); #1;
        chk1("busy_after_handoff", busy, 1'b0);
        chk("done_count", done_count, 32'(exp_done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0;
        flush = 1'b0; out_ready = 1'b1;
        v2 = 1'b0; op2 = 2'b00; a2 = '0; b2 = '0; ordy2 = 1'b1;
        #12;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_done_count", done_count, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        issue(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1); handoff();
        issue(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 1'b1); handoff();
        issue(2'b01, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 1'b1); handoff();
        issue(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); handoff();
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1); handoff();
        issue(2'b11, 32'h00010000, 32'h00010000, 32'h00000001, 1'b1); handoff();
        issue(2'b10, 32'h00000002, 32'h80000000, 32'h00000001, 1'b1); handoff();
        issue(2'b01, 32'h00000002, 32'h80000000, 32'hFFFFFFFF, 1'b1); handoff();
        issue(2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b1); handoff();
        issue(2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA, 1'b1); handoff();

        // Consumer stall in DONE
        out_ready = 1'b0;
        issue(2'b00, 32'h00001234, 32'h00000010, 32'h00012340, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk1("hold_out_valid", out_valid, 1'b1);
            chk("hold_out_result", out_result, 32'h00012340);
            chk1("hold_in_ready", in_ready, 1'b0);
            chk1("hold_busy", busy, 1'b1);
            chk("hold_done_count", done_count, 32'(exp_done));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        handoff();

        // Flush during CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd9; in_b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk) flush = 1'b1;
        chk1("flush_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk1("flush_calc_out_valid", out_valid, 1'b0);
            @(posedge clk); #1;
        end
        chk("flush_calc_done_count", done_count, 32'(exp_done));
        chk("flush_calc_out_result", out_result, 32'h00012340);
        issue(2'b00, 32'h00000003, 32'h00000005, 32'h0000000F, 1'b1); handoff();

        // Flush in DONE overrides out_ready
        issue(2'b00, 32'h00000006, 32'h00000007, 32'h0000002A, 1'b0);
        flush = 1'b1;
        chk("flush_done_result", out_result, 32'h0000002A);
        @(posedge clk); #1;
        flush = 1'b0;
        chk1("flush_done_out_valid", out_valid, 1'b0);
        chk1("flush_done_busy", busy, 1'b0);
        chk("flush_done_done_count", done_count, 32'(exp_done));
        chk("flush_done_out_result", out_result, 32'h0000002A);
        issue(2'b11, 32'h80000000, 32'h00000004, 32'h00000002, 1'b1); handoff();

        // Asynchronous reset mid-CALC
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd5; in_b = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_in_ready", in_ready, 1'b0);
        chk("arst_out_result", out_result, 32'h0);
        chk("arst_done_count", done_count, 32'h0);
        exp_done = 0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk1("arst_no_stale_valid", out_valid, 1'b0);
        end
        issue(2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1); handoff();

        // LATENCY=1 instance
        @(negedge clk);
        v2 = 1'b1; op2 = 2'b00; a2 = 32'h00000007; b2 = 32'hFFFFFFFD;
        chk1("l1_in_ready", rdy2, 1'b1);
        @(posedge clk); #1;
        v2 = 1'b0; a2 = 32'h0; b2 = 32'h0;
        k = 1;
        while (!ov2 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("l1_latency", 32'(k), 32'd3);
        chk("l1_result", res2, 32'hFFFFFFEB);
        @(posedge clk); #1;
        chk("l1_done_count", dc2, 32'd1);
        chk1("l1_busy", busy2, 1'b0);

        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
